// File: rtl/readout_pkg.sv
// Shared types for the capture-buffer readout block: FSM state encoding and
// the sample-to-byte sizing helper used by the readout top and its handshake.
package readout_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_MEM = 3'd2,
        SEND     = 3'd3,
        WAIT_HI  = 3'd4,
        WAIT_LO  = 3'd5,
        CHKSUM   = 3'd6,
        DONE     = 3'd7
    } readout_state_t;

    function automatic int unsigned bytes_per_sample(input int unsigned width);
        return (width + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/sample_readout_if.sv
// Capture-RAM read port plus UART byte handshake, grouped for the readout block.
// master = readout side, slave = RAM/UART side.
interface sample_readout_if #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10
);
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_rd_en;
    logic [SAMPLE_WIDTH-1:0] mem_data;
    logic                    tx_busy;
    logic                    trans_en;
    logic [7:0]              tx_byte;

    modport master (
        output mem_addr, mem_rd_en, trans_en, tx_byte,
        input  mem_data, tx_busy
    );

    modport slave (
        input  mem_addr, mem_rd_en, trans_en, tx_byte,
        output mem_data, tx_busy
    );
endinterface

// File: rtl/tx_byte_handshake.sv
// Single-byte UART handshake: launches a byte when the UART is idle, then tracks
// tx_busy high and low again; ack pulses in the cycle tx_busy is seen falling.
module tx_byte_handshake
    import readout_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] req_byte,
    input  logic       tx_busy,
    output logic       ack,
    output logic       trans_en,
    output logic [7:0] tx_byte
);

    readout_state_t hs_state_q, hs_state_d;
    logic           trans_en_q, trans_en_d;
    logic [7:0]     tx_byte_q,  tx_byte_d;

    // Next-state logic for the launch / wait-high / wait-low sequence.
    always_comb begin
        hs_state_d = hs_state_q;
        trans_en_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        case (hs_state_q)
            IDLE: begin
                if (req && !tx_busy) begin
                    trans_en_d = 1'b1;
                    tx_byte_d  = req_byte;
                    hs_state_d = WAIT_HI;
                end else begin
                    hs_state_d = IDLE;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    hs_state_d = WAIT_LO;
                end else begin
                    hs_state_d = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    hs_state_d = IDLE;
                end else begin
                    hs_state_d = WAIT_LO;
                end
            end
            default: hs_state_d = IDLE;
        endcase
    end

    // Handshake state and registered UART outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs_state_q <= IDLE;
            trans_en_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            hs_state_q <= hs_state_d;
            trans_en_q <= trans_en_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Combinational so the parent can advance on the same edge the byte completes.
    assign ack      = (hs_state_q == WAIT_LO) && !tx_busy;
    assign trans_en = trans_en_q;
    assign tx_byte  = tx_byte_q;

endmodule

// File: rtl/sample_readout.sv
// Reads captured samples newest-first and streams them LSB byte first to the UART.
// Optional READOUT_CHECKSUM_EN appends an XOR-of-all-bytes after the last sample.
module sample_readout
    import readout_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic [ADDR_WIDTH:0]   read_count,
    output logic                  busy,
    output logic                  done,
    sample_readout_if.master      bus
);

    localparam int BPS = int'(bytes_per_sample(SAMPLE_WIDTH));
    localparam int SW  = BPS * 8;
    localparam logic [7:0]            LAST_IDX = 8'(BPS - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`ifdef READOUT_CHECKSUM_EN
    localparam readout_state_t AFTER_LAST = CHKSUM;
`else
    localparam readout_state_t AFTER_LAST = DONE;
`endif

    readout_state_t        state_q, state_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SW-1:0]         shift_q, shift_d;
    logic [7:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef READOUT_CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
`endif

    logic       hs_req_s;
    logic [7:0] hs_byte_s;
    logic       hs_ack_s;

    // Byte source for the handshake: the sample shifter, or the checksum.
    always_comb begin
        hs_req_s  = (state_q == SEND);
        hs_byte_s = shift_q[7:0];
`ifdef READOUT_CHECKSUM_EN
        if (state_q == CHKSUM) begin
            hs_req_s  = 1'b1;
            hs_byte_s = xor_q;
        end else begin
            hs_req_s  = (state_q == SEND);
        end
`endif
    end

    tx_byte_handshake u_hs (
        .clock    (clock),
        .reset    (reset),
        .req      (hs_req_s),
        .req_byte (hs_byte_s),
        .tx_busy  (bus.tx_busy),
        .ack      (hs_ack_s),
        .trans_en (bus.trans_en),
        .tx_byte  (bus.tx_byte)
    );

    // Fetch / serialize / count sequencing.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef READOUT_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    remaining_d = (read_count > DEPTH) ? DEPTH : read_count;
                    addr_d      = last_addr;
                    busy_d      = 1'b1;
`ifdef READOUT_CHECKSUM_EN
                    xor_d       = 8'h00;
`endif
                    if (remaining_d == '0) begin
                        state_d = AFTER_LAST;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            FETCH: state_d = WAIT_MEM;
            WAIT_MEM: begin
                shift_d                    = '0;
                shift_d[SAMPLE_WIDTH-1:0]  = bus.mem_data;
                byte_idx_d                 = 8'd0;
                state_d                    = SEND;
            end
            SEND: begin
                if (hs_ack_s) begin
                    shift_d    = shift_q >> 8;
                    byte_idx_d = byte_idx_q + 8'd1;
`ifdef READOUT_CHECKSUM_EN
                    xor_d      = xor_q ^ shift_q[7:0];
`endif
                    if (abort) begin
                        state_d = DONE;
                    end else if (byte_idx_q < LAST_IDX) begin
                        state_d = SEND;
                    end else begin
                        remaining_d = remaining_q - ONE_CNT;
                        addr_d      = addr_q - ONE_ADDR;
                        if (remaining_d != '0) begin
                            state_d = FETCH;
                        end else begin
                            state_d = AFTER_LAST;
                        end
                    end
                end else begin
                    state_d = SEND;
                end
            end
`ifdef READOUT_CHECKSUM_EN
            CHKSUM: begin
                if (hs_ack_s) begin
                    state_d = DONE;
                end else begin
                    state_d = CHKSUM;
                end
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        mem_rd_en_d = (state_d == FETCH);
        mem_addr_d  = (state_d == FETCH) ? addr_d : mem_addr_q;
    end

    // Controller state, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            shift_q     <= '0;
            byte_idx_q  <= 8'd0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            xor_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef READOUT_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd_en = mem_rd_en_q;

endmodule

// File: tb/tb_sample_readout.sv
// Directed scoreboard bench for sample_readout: an 8-bit and a 16-bit instance,
// each with a RAM model and a UART model that stays busy for 10 cycles per byte.
module tb_sample_readout;
    import readout_pkg::*;

`ifdef READOUT_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic abort;
    logic start8, start16;
    logic [9:0]  last8, last16;
    logic [10:0] cnt8, cnt16;
    logic busy8, done8, busy16, done16;

    int checks = 0;
    int errors = 0;
    int tx_cnt8 = 0, tx_cnt16 = 0, done_cnt8 = 0, done_cnt16 = 0;
    int b8, d8, b16, d16;

    logic [7:0] exp8[$];
    logic [7:0] exp16[$];
    logic [9:0] ea8[$];
    logic [9:0] ea16[$];

    logic [7:0]  ram8  [0:1023];
    logic [15:0] ram16 [0:1023];
    logic [7:0]  rdata8;
    logic [15:0] rdata16;
    int ucnt8 = 0, ucnt16 = 0;

    always #5 clk = ~clk;

    sample_readout_if #(.SAMPLE_WIDTH(8),  .ADDR_WIDTH(10)) if8 ();
    sample_readout_if #(.SAMPLE_WIDTH(16), .ADDR_WIDTH(10)) if16 ();

    sample_readout #(.SAMPLE_WIDTH(8), .ADDR_WIDTH(10)) dut8 (
        .clock(clk), .reset(reset), .start(start8), .abort(abort),
        .last_addr(last8), .read_count(cnt8), .busy(busy8), .done(done8), .bus(if8)
    );

    sample_readout #(.SAMPLE_WIDTH(16), .ADDR_WIDTH(10)) dut16 (
        .clock(clk), .reset(reset), .start(start16), .abort(abort),
        .last_addr(last16), .read_count(cnt16), .busy(busy16), .done(done16), .bus(if16)
    );

    // RAM read ports: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (if8.mem_rd_en)  rdata8  <= ram8[if8.mem_addr];
        if (if16.mem_rd_en) rdata16 <= ram16[if16.mem_addr];
    end
    assign if8.mem_data  = rdata8;
    assign if16.mem_data = rdata16;

    // UART models: busy rises the cycle after trans_en and lasts 10 cycles.
    always @(posedge clk) begin
        if (if8.trans_en) ucnt8 <= 10; else if (ucnt8 != 0) ucnt8 <= ucnt8 - 1;
        if (if16.trans_en) ucnt16 <= 10; else if (ucnt16 != 0) ucnt16 <= ucnt16 - 1;
    end
    assign if8.tx_busy  = (ucnt8 != 0);
    assign if16.tx_busy = (ucnt16 != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop expected bytes / addresses as the DUTs produce them.
    always @(negedge clk) begin
        logic [31:0] e;
        if (if8.trans_en) begin
            tx_cnt8++;
            chk("te_while_busy8", 32'(if8.tx_busy), 32'd0);
            e = 32'hFFFF_FFFF;
            if (exp8.size() != 0) e = 32'(exp8.pop_front());
            chk("tx_byte8", 32'(if8.tx_byte), e);
        end
        if (if16.trans_en) begin
            tx_cnt16++;
            chk("te_while_busy16", 32'(if16.tx_busy), 32'd0);
            e = 32'hFFFF_FFFF;
            if (exp16.size() != 0) e = 32'(exp16.pop_front());
            chk("tx_byte16", 32'(if16.tx_byte), e);
        end
        if (if8.mem_rd_en) begin
            e = 32'hFFFF_FFFF;
            if (ea8.size() != 0) e = 32'(ea8.pop_front());
            chk("mem_addr8", 32'(if8.mem_addr), e);
        end
        if (if16.mem_rd_en) begin
            e = 32'hFFFF_FFFF;
            if (ea16.size() != 0) e = 32'(ea16.pop_front());
            chk("mem_addr16", 32'(if16.mem_addr), e);
        end
        if (done8)  done_cnt8++;
        if (done16) done_cnt16++;
    end

    task automatic wait_done(input bit which, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = which ? done16 : done8;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_tx8(input int target, input string tag);
        for (int i = 0; i < 400 && tx_cnt8 < target; i++) @(negedge clk);
        chk(tag, 32'(tx_cnt8), 32'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_8"},  32'({busy8, done8, if8.trans_en, if8.tx_byte, if8.mem_rd_en, if8.mem_addr}), 32'd0);
        chk({tag, "_16"}, 32'({busy16, done16, if16.trans_en, if16.tx_byte, if16.mem_rd_en, if16.mem_addr}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; abort = 1'b0;
        start8 = 1'b0; start16 = 1'b0;
        last8 = 10'd0; last16 = 10'd0; cnt8 = 11'd0; cnt16 = 11'd0;
        ram8[5] = 8'hA5; ram8[4] = 8'h3C; ram8[3] = 8'h01;
        ram8[10] = 8'h11; ram8[9] = 8'h22; ram8[8] = 8'h33; ram8[7] = 8'h44;
        ram16[0] = 16'h1234; ram16[1023] = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic 3-sample readout, latency, and a second start while busy.
        b8 = tx_cnt8; d8 = done_cnt8;
        exp8.push_back(8'hA5); exp8.push_back(8'h3C); exp8.push_back(8'h01);
        if (CK != 0) exp8.push_back(8'h98);
        ea8.push_back(10'd5); ea8.push_back(10'd4); ea8.push_back(10'd3);
        last8 = 10'd5; cnt8 = 11'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy_after_start", 32'(busy8), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("latency4", 32'(if8.trans_en), 32'd1);
        start8 = 1'b1; cnt8 = 11'd1; last8 = 10'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done(1'b0, 600, "t1_done");
        @(negedge clk);
        chk("t1_busy_low", 32'(busy8), 32'd0);
        chk("t1_nbytes", 32'(tx_cnt8 - b8), 32'(3 + CK));
        chk("t1_ndone", 32'(done_cnt8 - d8), 32'd1);
        chk("t1_left", 32'(exp8.size() + ea8.size()), 32'd0);

        // 16-bit samples with address wrap 0 -> 1023.
        b16 = tx_cnt16; d16 = done_cnt16;
        exp16.push_back(8'h34); exp16.push_back(8'h12); exp16.push_back(8'hEF); exp16.push_back(8'hBE);
        if (CK != 0) exp16.push_back(8'h77);
        ea16.push_back(10'd0); ea16.push_back(10'd1023);
        last16 = 10'd0; cnt16 = 11'd2; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        wait_done(1'b1, 800, "t2_done");
        @(negedge clk);
        chk("t2_busy_low", 32'(busy16), 32'd0);
        chk("t2_nbytes", 32'(tx_cnt16 - b16), 32'(4 + CK));
        chk("t2_ndone", 32'(done_cnt16 - d16), 32'd1);
        chk("t2_left", 32'(exp16.size() + ea16.size()), 32'd0);

        // Zero-length readout.
        b8 = tx_cnt8; d8 = done_cnt8;
        if (CK != 0) exp8.push_back(8'h00);
        last8 = 10'd7; cnt8 = 11'd0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("t3_no_done_yet", 32'(done8), 32'd0);
`ifdef READOUT_CHECKSUM_EN
        wait_done(1'b0, 300, "t3_done");
`else
        @(posedge clk); #1;
        chk("t3_done_2cyc", 32'(done8), 32'd1);
`endif
        repeat (2) @(negedge clk);
        chk("t3_nbytes", 32'(tx_cnt8 - b8), 32'(CK));
        chk("t3_ndone", 32'(done_cnt8 - d8), 32'd1);

        // Abort while the 2nd of 4 samples is on the wire.
        b8 = tx_cnt8; d8 = done_cnt8;
        exp8.push_back(8'h11); exp8.push_back(8'h22);
        ea8.push_back(10'd10); ea8.push_back(10'd9);
        last8 = 10'd10; cnt8 = 11'd4; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_tx8(b8 + 2, "t4_second_byte");
        abort = 1'b1;
        wait_done(1'b0, 400, "t4_done");
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_nbytes", 32'(tx_cnt8 - b8), 32'd2);
        chk("t4_ndone", 32'(done_cnt8 - d8), 32'd1);
        chk("t4_left", 32'(exp8.size() + ea8.size()), 32'd0);

        // Ignored restart, then reset while waiting for the UART to finish.
        b8 = tx_cnt8; d8 = done_cnt8;
        exp8.push_back(8'hA5);
        ea8.push_back(10'd5);
        last8 = 10'd5; cnt8 = 11'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_tx8(b8 + 1, "t5_first_byte");
        @(posedge clk); #1;
        start8 = 1'b1; cnt8 = 11'd2; last8 = 10'd9;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_uart_busy", 32'(if8.tx_busy), 32'd1);
        reset = 1'b0;
        #1;
        check_idle_outputs("t5_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp8.push_back(8'h01);
        if (CK != 0) exp8.push_back(8'h01);
        ea8.push_back(10'd3);
        last8 = 10'd3; cnt8 = 11'd1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done(1'b0, 400, "t5_done");
        repeat (2) @(negedge clk);
        chk("t5_nbytes", 32'(tx_cnt8 - b8), 32'(2 + CK));
        chk("t5_ndone", 32'(done_cnt8 - d8), 32'd1);
        chk("t5_left", 32'(exp8.size() + ea8.size()), 32'd0);
        chk("t5_busy_low", 32'(busy8), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
